encoder_4_x_2_seq: RTL and testbench
====================================

Name: encoder_4_x_2_seq

Overview:
Registered 4-to-2 priority encoder, the inverse of the team's 2x4 decoder. It collects active-low request lines into a sticky pending register and encodes the winner as the 2-bit code {A,B}, with A as the MSB. The code is presented with a valid/ready handshake and the served request is retired on acceptance. It sits on the return path where decoded select lines must be folded back into a binary index.

Parameters:
LOW_IDX_FIRST, 1, fixed-priority order: 1 means index 0 is highest priority; 0 means index 3 is highest.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
enable  input  1  active-low sample enable; requests are captured only when enable=0.
D  input  [0:3]  active-low request lines; D[i]=0 requests index i.
ready  input  1  consumer accepts the presented code.
A  output  1  code MSB.
B  output  1  code LSB.
valid  output  1  code on {A,B} is valid.
GS  output  1  active-low group signal; 0 while any pending bit is set.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: on any edge with rst=1, all state clears.
- Reset values: pending=0000, state=IDLE, A=0, B=0, valid=0, GS=1.
- Capture: at each edge with enable=0, pending[i] <= pending[i] | ~D[i].
  - With enable=1, pending holds and new requests are ignored.
  - Capture is independent of FSM state.
- FSM, two states:
  - IDLE: if pending!=0 (registered value), load {A,B} with the highest-priority pending index, set valid=1, go to PRESENT. Otherwise stay and keep valid=0.
  - PRESENT: hold {A,B} and valid stable while ready=0.
  - On valid&&ready at an edge: clear pending[{A,B}], drop valid to 0, return to IDLE.
- Latency: a request sampled at edge k gives valid=1 after edge k+1. Maximum throughput is one code per 2 cycles.
- A and B keep their last value after valid falls. The consumer samples them only while valid=1.
- Simultaneous set and clear on the same bit at the same edge: set wins. The request stays pending and is re-served later.
- Requests arriving while in PRESENT do not change the code being presented. They are arbitrated at the next IDLE.
- GS is registered: GS = ~|pending_next, and updates on the same edge as pending.
- ready while valid=0 is ignored.
- Reset asserted mid-handshake drops valid at that edge and discards all pending requests.
- Index encoding: index i maps to {A,B} = i, so 0->00, 1->01, 2->10, 3->11. This matches the decoder mapping.

Optional Feature:
ROUND_ROBIN_EN
- Defined: a 2-bit pointer (reset 00) records last_granted+1 mod 4 after each handshake. The IDLE search starts at the pointer and wraps 3->0. LOW_IDX_FIRST is ignored.
- Undefined: fixed priority per LOW_IDX_FIRST, and no pointer register exists.

Decomposition:
- Package encoder_pkg holds:
  - state enum {IDLE, PRESENT};
  - constant N_REQ=4;
  - constant IDX_W=2;
  - helper function idx_to_code.
- One sub-module, prio_pick: purely combinational. Inputs are the 4-bit request vector and a 2-bit start index. Outputs are the 2-bit index and a found flag. Fixed priority drives start=0, or the reversed vector when LOW_IDX_FIRST=0. Round-robin drives start from the pointer.

Test Plan:
1. Reset, then D=1101 (req 2) with enable=0 for one cycle and ready=1 → valid=1 one edge later with {A,B}=10, GS=0. After the handshake, valid=0 and GS=1.
2. D=0110 (req 0 and 3) for one cycle, ready=1, LOW_IDX_FIRST=1 → codes 00 then 11 on consecutive valid pulses, 2 cycles apart. With LOW_IDX_FIRST=0 → 11 then 00.
3. Request 1 pending, ready=0 for 5 cycles → {A,B}=01 and valid=1 stay stable. Then D=1110 (req 3) arrives → code stays 01 until accepted, and 11 follows.
4. Request 2 presented; at the accepting edge D[2]=0 is applied again → pending[2] stays set and code 10 is re-presented.
5. enable=1 with D=0000 for 3 cycles → pending stays 0000, valid=0, GS=1. Separately, pending=1111 in PRESENT with rst=1 for one edge → valid=0, GS=1, and no further codes.
6. With ROUND_ROBIN_EN defined: D=0000 held, ready=1 → codes 00, 01, 10, 11, 00 in order. Without it → code 00 repeats.

Source files
------------

// File: rtl/encoder_4_x_2_seq_pkg.sv
// rtl/encoder_4_x_2_seq_pkg.sv - shared types and constants for the 4x2 sequential priority encoder
package encoder_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Request index i is presented as {A,B} = i, mirroring the 2x4 decoder.
    function automatic logic [1:0] idx_to_code(input logic [IDX_W-1:0] idx);
        return {idx[1], idx[0]};
    endfunction

endpackage

// File: rtl/encoder_4_x_2_seq_if.sv
// rtl/encoder_4_x_2_seq_if.sv - request/code handshake bundle for encoder_4_x_2_seq
interface encoder_4_x_2_seq_if;

    logic       enable;
    logic [0:3] D;
    logic       ready;
    logic       A;
    logic       B;
    logic       valid;
    logic       GS;

    modport master (
        input  enable,
        input  D,
        input  ready,
        output A,
        output B,
        output valid,
        output GS
    );

    modport slave (
        output enable,
        output D,
        output ready,
        input  A,
        input  B,
        input  valid,
        input  GS
    );

endinterface

// File: rtl/encoder_4_x_2_seq_prio_pick.sv
// rtl/encoder_4_x_2_seq_prio_pick.sv - combinational first-set search over 4 requests, starting at a given index
module prio_pick
    import encoder_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Walk offsets from the far end back to start so the nearest set bit wins.
    always_comb begin
        idx   = start;
        found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[start + IDX_W'(k)]) begin
                idx   = start + IDX_W'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_4_x_2_seq.sv
// rtl/encoder_4_x_2_seq.sv - registered 4-to-2 priority encoder with sticky pending requests and valid/ready output
// Optional ROUND_ROBIN_EN: rotating search start instead of fixed LOW_IDX_FIRST priority.
module encoder_4_x_2_seq
    import encoder_pkg::*;
#(
    parameter int LOW_IDX_FIRST = 1
)
(
    input  logic                   clk,
    input  logic                   rst,
    encoder_4_x_2_seq_if.master    bus
);

    state_t             state_q;
    state_t             state_d;
    logic [N_REQ-1:0]   pending_q;
    logic [N_REQ-1:0]   pending_d;
    logic [IDX_W-1:0]   code_q;
    logic [IDX_W-1:0]   code_d;
    logic               gs_q;
    logic               gs_d;

    logic [N_REQ-1:0]   req_set;
    logic               accept;
    logic [N_REQ-1:0]   pick_req;
    logic [IDX_W-1:0]   pick_start;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [IDX_W-1:0]   win_idx;

    // D is declared [0:3]; fold it into the [3:0] pending order here.
    assign req_set = {~bus.D[3], ~bus.D[2], ~bus.D[1], ~bus.D[0]} & {N_REQ{~bus.enable}};
    assign accept  = (state_q == PRESENT) && bus.ready;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    assign pick_req   = pending_q;
    assign pick_start = ptr_q;
    assign win_idx    = pick_idx;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = code_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // High-index-first reuses the same search on a bit-reversed vector.
    assign pick_start = '0;
    assign pick_req   = (LOW_IDX_FIRST != 0) ? pending_q
                                             : {pending_q[0], pending_q[1], pending_q[2], pending_q[3]};
    assign win_idx    = (LOW_IDX_FIRST != 0) ? pick_idx : ~pick_idx;
`endif

    prio_pick u_pick (
        .req   (pick_req),
        .start (pick_start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Clear the served bit before OR-ing new requests so a same-edge re-request survives.
    always_comb begin
        pending_d = pending_q;
        if (accept) begin
            pending_d[code_q] = 1'b0;
        end
        pending_d = pending_d | req_set;
        gs_d      = ~|pending_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            code_q    <= '0;
            gs_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            gs_q      <= gs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = PRESENT;
                    code_d  = idx_to_code(win_idx);
                end
            end
            PRESENT: begin
                if (bus.ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.valid = (state_q == PRESENT);
        bus.A     = code_q[1];
        bus.B     = code_q[0];
        bus.GS    = gs_q;
    end

endmodule

// File: tb/tb_encoder_4_x_2_seq.sv
// tb/tb_encoder_4_x_2_seq.sv - self-checking bench for encoder_4_x_2_seq (both priority orders)
module tb_encoder_4_x_2_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [0:3] d;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    encoder_4_x_2_seq_if bus_lo ();
    encoder_4_x_2_seq_if bus_hi ();

    assign bus_lo.enable = en;
    assign bus_lo.D      = d;
    assign bus_lo.ready  = rdy;
    assign bus_hi.enable = en;
    assign bus_hi.D      = d;
    assign bus_hi.ready  = rdy;

    encoder_4_x_2_seq #(.LOW_IDX_FIRST(1)) dut_lo (.clk(clk), .rst(rst), .bus(bus_lo));
    encoder_4_x_2_seq #(.LOW_IDX_FIRST(0)) dut_hi (.clk(clk), .rst(rst), .bus(bus_hi));

    // Reference: index 0 models dut_lo, index 1 models dut_hi.
    bit [3:0] mp [2];
    bit       mv [2];
    bit [1:0] mc [2];
`ifdef ROUND_ROBIN_EN
    bit [1:0] mptr [2];

    function automatic bit [1:0] rr_pick(input bit [3:0] p, input bit [1:0] ptr);
        for (int k = 0; k < 4; k++) begin
            if (p[ptr + 2'(k)]) return ptr + 2'(k);
        end
        return 2'd0;
    endfunction
`else
    function automatic bit [1:0] fixed_pick(input bit [3:0] p, input bit low_first);
        if (low_first) begin
            for (int i = 0; i < 4; i++) if (p[2'(i)]) return 2'(i);
        end else begin
            for (int i = 3; i >= 0; i--) if (p[2'(i)]) return 2'(i);
        end
        return 2'd0;
    endfunction
`endif

    task automatic model_edge();
        bit [3:0] reqs;
        bit [3:0] np;
        bit       served;
        for (int i = 0; i < 4; i++) reqs[2'(i)] = !en && !d[2'(i)];
        for (int n = 0; n < 2; n++) begin
            if (rst) begin
                mp[n] = '0;
                mv[n] = 1'b0;
                mc[n] = '0;
`ifdef ROUND_ROBIN_EN
                mptr[n] = '0;
`endif
            end else begin
                served = mv[n] && rdy;
                np = mp[n];
                if (served) np[mc[n]] = 1'b0;
                np = np | reqs;
                if (served) begin
                    mv[n] = 1'b0;
`ifdef ROUND_ROBIN_EN
                    mptr[n] = mc[n] + 2'd1;
`endif
                end else if (!mv[n] && mp[n] != 0) begin
`ifdef ROUND_ROBIN_EN
                    mc[n] = rr_pick(mp[n], mptr[n]);
`else
                    mc[n] = fixed_pick(mp[n], n == 0);
`endif
                    mv[n] = 1'b1;
                end
                mp[n] = np;
            end
        end
    endtask

    function automatic logic [3:0] ol();
        return {bus_lo.valid, bus_lo.GS, bus_lo.A, bus_lo.B};
    endfunction

    function automatic logic [3:0] oh();
        return {bus_hi.valid, bus_hi.GS, bus_hi.A, bus_hi.B};
    endfunction

    function automatic logic [3:0] mexp(input int n);
        return {mv[n], mp[n] == 0, mc[n]};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; d = 4'b1111; rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 2;
        if (ol() !== 4'b0100) $display("FAIL reset_lo: got %b want %b", ol(), 4'b0100); else passes++;
        if (oh() !== 4'b0100) $display("FAIL reset_hi: got %b want %b", oh(), 4'b0100); else passes++;
    endtask

    task automatic test_single();
        do_reset();
        rdy = 1'b1; en = 1'b0; d = 4'b1101;
        tick();
        en = 1'b1; d = 4'b1111;
        checks++;
        if (ol() !== 4'b0000) $display("FAIL single_capture: got %b want %b", ol(), 4'b0000); else passes++;
        tick();
        checks++;
        if (ol() !== 4'b1010) $display("FAIL single_present: got %b want %b", ol(), 4'b1010); else passes++;
        tick();
        checks++;
        if (ol() !== 4'b0110) $display("FAIL single_done: got %b want %b", ol(), 4'b0110); else passes++;
    endtask

    task automatic test_two_requests();
        logic [1:0] first_hi;
        logic [1:0] second_hi;
`ifdef ROUND_ROBIN_EN
        first_hi = 2'b00; second_hi = 2'b11;
`else
        first_hi = 2'b11; second_hi = 2'b00;
`endif
        do_reset();
        rdy = 1'b1; en = 1'b0; d = 4'b0110;
        tick();
        en = 1'b1; d = 4'b1111;
        tick();
        checks += 2;
        if (ol() !== 4'b1000) $display("FAIL two_first_lo: got %b want %b", ol(), 4'b1000); else passes++;
        if (oh() !== {2'b10, first_hi}) $display("FAIL two_first_hi: got %b want %b", oh(), {2'b10, first_hi}); else passes++;
        tick();
        checks++;
        if (ol() !== 4'b0000) $display("FAIL two_gap_lo: got %b want %b", ol(), 4'b0000); else passes++;
        tick();
        checks += 2;
        if (ol() !== 4'b1011) $display("FAIL two_second_lo: got %b want %b", ol(), 4'b1011); else passes++;
        if (oh() !== {2'b10, second_hi}) $display("FAIL two_second_hi: got %b want %b", oh(), {2'b10, second_hi}); else passes++;
        tick();
        checks++;
        if (ol() !== 4'b0111) $display("FAIL two_done_lo: got %b want %b", ol(), 4'b0111); else passes++;
    endtask

    task automatic test_hold_stable();
        do_reset();
        rdy = 1'b0; en = 1'b0; d = 4'b1011;
        tick();
        en = 1'b1; d = 4'b1111;
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            checks += 2;
            if (ol() !== 4'b1001) $display("FAIL hold_lo cycle %0d: got %b want %b", c, ol(), 4'b1001); else passes++;
            if (oh() !== 4'b1001) $display("FAIL hold_hi cycle %0d: got %b want %b", c, oh(), 4'b1001); else passes++;
        end
        en = 1'b0; d = 4'b1110;
        tick();
        en = 1'b1; d = 4'b1111;
        tick();
        checks++;
        if (ol() !== 4'b1001) $display("FAIL hold_late_req: got %b want %b", ol(), 4'b1001); else passes++;
        rdy = 1'b1;
        tick();
        checks++;
        if (ol() !== 4'b0001) $display("FAIL hold_accept: got %b want %b", ol(), 4'b0001); else passes++;
        tick();
        checks++;
        if (ol() !== 4'b1011) $display("FAIL hold_next: got %b want %b", ol(), 4'b1011); else passes++;
        tick();
        rdy = 1'b0;
    endtask

    task automatic test_set_wins();
        do_reset();
        rdy = 1'b0; en = 1'b0; d = 4'b1101;
        tick();
        en = 1'b1; d = 4'b1111;
        tick();
        rdy = 1'b1; en = 1'b0; d = 4'b1101;
        tick();
        en = 1'b1; d = 4'b1111;
        checks++;
        if (ol() !== 4'b0010) $display("FAIL setwins_accept: got %b want %b", ol(), 4'b0010); else passes++;
        tick();
        checks++;
        if (ol() !== 4'b1010) $display("FAIL setwins_again: got %b want %b", ol(), 4'b1010); else passes++;
        tick();
        checks++;
        if (ol() !== 4'b0110) $display("FAIL setwins_done: got %b want %b", ol(), 4'b0110); else passes++;
    endtask

    task automatic test_enable_and_reset();
        logic [1:0] hi_code;
`ifdef ROUND_ROBIN_EN
        hi_code = 2'b00;
`else
        hi_code = 2'b11;
`endif
        do_reset();
        rdy = 1'b1; en = 1'b1; d = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (ol() !== 4'b0100) $display("FAIL enable_ignore cycle %0d: got %b want %b", c, ol(), 4'b0100); else passes++;
        end
        rdy = 1'b0; en = 1'b0;
        tick();
        en = 1'b1; d = 4'b1111;
        tick();
        checks += 2;
        if (ol() !== 4'b1000) $display("FAIL all_present_lo: got %b want %b", ol(), 4'b1000); else passes++;
        if (oh() !== {2'b10, hi_code}) $display("FAIL all_present_hi: got %b want %b", oh(), {2'b10, hi_code}); else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0; rdy = 1'b1;
        checks += 2;
        if (ol() !== 4'b0100) $display("FAIL midreset_lo: got %b want %b", ol(), 4'b0100); else passes++;
        if (oh() !== 4'b0100) $display("FAIL midreset_hi: got %b want %b", oh(), 4'b0100); else passes++;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (ol() !== 4'b0100) $display("FAIL after_reset cycle %0d: got %b want %b", c, ol(), 4'b0100); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] c_lo [5];
        logic [1:0] c_hi [5];
        logic [1:0] e_lo;
        logic [1:0] e_hi;
        int n_lo = 0;
        int n_hi = 0;
        do_reset();
        rdy = 1'b1; en = 1'b0; d = 4'b0000;
        tick();
        for (int c = 0; c < 24 && (n_lo < 5 || n_hi < 5); c++) begin
            tick();
            if (bus_lo.valid && n_lo < 5) begin c_lo[n_lo] = {bus_lo.A, bus_lo.B}; n_lo++; end
            if (bus_hi.valid && n_hi < 5) begin c_hi[n_hi] = {bus_hi.A, bus_hi.B}; n_hi++; end
        end
        checks += 2;
        if (n_lo != 5) $display("FAIL b2b_count_lo: got %0d want 5", n_lo); else passes++;
        if (n_hi != 5) $display("FAIL b2b_count_hi: got %0d want 5", n_hi); else passes++;
        for (int k = 0; k < n_lo; k++) begin
`ifdef ROUND_ROBIN_EN
            e_lo = 2'(k);
`else
            e_lo = 2'b00;
`endif
            checks++;
            if (c_lo[k] !== e_lo) $display("FAIL b2b_code_lo #%0d: got %b want %b", k, c_lo[k], e_lo); else passes++;
        end
        for (int k = 0; k < n_hi; k++) begin
`ifdef ROUND_ROBIN_EN
            e_hi = 2'(k);
`else
            e_hi = 2'b11;
`endif
            checks++;
            if (c_hi[k] !== e_hi) $display("FAIL b2b_code_hi #%0d: got %b want %b", k, c_hi[k], e_hi); else passes++;
        end
        en = 1'b1; d = 4'b1111;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            en  = ($urandom_range(0, 3) == 0);
            d   = 4'($urandom) | 4'($urandom);
            rdy = 1'($urandom_range(0, 1));
            tick();
            checks += 2;
            if (ol() !== mexp(0)) $display("FAIL random_lo cycle %0d: got %b want %b", c, ol(), mexp(0)); else passes++;
            if (oh() !== mexp(1)) $display("FAIL random_hi cycle %0d: got %b want %b", c, oh(), mexp(1)); else passes++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_requests();
        test_hold_stable();
        test_set_wins();
        test_enable_and_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
